// File: rtl/i2d_core_defines.sv
// Shared core definitions: operand source selects and the register address width.
// The enum encodings are kept stable because older decode logic depends on them.
package i2d_core_defines;

    localparam int RADDR_DEFAULT = 5;

    typedef enum logic [1:0] {
        OPMUX_A_RA = 2'd0,
        OPMUX_A_PC = 2'd1,
        OPMUX_A_WB = 2'd2
    } opmux_a_t;

    typedef enum logic [1:0] {
        OPMUX_B_RB  = 2'd0,
        OPMUX_B_PC  = 2'd1,
        OPMUX_B_IMM = 2'd2,
        OPMUX_B_WB  = 2'd3
    } opmux_b_t;

endpackage

// File: rtl/core_fwd_select.sv
// Forwarding priority match for one register operand.
// Slot 0 is the youngest write and wins over every older slot; register 0 never forwards.
module core_fwd_select #(
    parameter int XLEN  = 32,
    parameter int NFWD  = 2,
    parameter int RADDR = 5
) (
    input  logic [RADDR-1:0]      addr,
    input  logic [XLEN-1:0]       rf_data,
    input  logic [NFWD-1:0]       fwd_valid,
    input  logic [NFWD-1:0]       fwd_pending,
    input  logic [NFWD*RADDR-1:0] fwd_addr,
    input  logic [NFWD*XLEN-1:0]  fwd_data,
    output logic [XLEN-1:0]       data,
    output logic                  pending
);

    // Walk from the oldest slot to the youngest so the youngest match is the last one written
    always_comb begin
        data    = rf_data;
        pending = 1'b0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if ((addr != '0) && fwd_valid[i] && (fwd_addr[i*RADDR +: RADDR] == addr)) begin
                data    = fwd_data[i*XLEN +: XLEN];
                pending = fwd_pending[i];
            end
        end
    end

endmodule

// File: rtl/core_operand_stage.sv
// Operand stage: resolves forwarding, selects operand sources, detects load-use hazards
// and holds the operand pair in a single-entry valid/ready register towards execute.
module core_operand_stage
    import i2d_core_defines::*;
#(
    parameter int XLEN  = 32,
    parameter int NFWD  = 2,
    parameter int RADDR = RADDR_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  opmux_a_t              opmux_a,
    input  opmux_b_t              opmux_b,
    input  logic [RADDR-1:0]      rega_addr,
    input  logic [RADDR-1:0]      regb_addr,
    input  logic [XLEN-1:0]       rega_data,
    input  logic [XLEN-1:0]       regb_data,
    input  logic [XLEN-1:0]       imm,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [NFWD-1:0]       fwd_valid,
    input  logic [NFWD-1:0]       fwd_pending,
    input  logic [NFWD*RADDR-1:0] fwd_addr,
    input  logic [NFWD*XLEN-1:0]  fwd_data,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [XLEN-1:0]       operand_a,
    output logic [XLEN-1:0]       operand_b,
    output logic                  hazard
);

    logic [XLEN-1:0] res_a;
    logic [XLEN-1:0] res_b;
    logic [XLEN-1:0] wb_data;
    logic [XLEN-1:0] next_a;
    logic [XLEN-1:0] next_b;
    logic            pend_a;
    logic            pend_b;
    logic            accept;

    core_fwd_select #(
        .XLEN  (XLEN),
        .NFWD  (NFWD),
        .RADDR (RADDR)
    ) u_fwd_a (
        .addr        (rega_addr),
        .rf_data     (rega_data),
        .fwd_valid   (fwd_valid),
        .fwd_pending (fwd_pending),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .data        (res_a),
        .pending     (pend_a)
    );

    core_fwd_select #(
        .XLEN  (XLEN),
        .NFWD  (NFWD),
        .RADDR (RADDR)
    ) u_fwd_b (
        .addr        (regb_addr),
        .rf_data     (regb_data),
        .fwd_valid   (fwd_valid),
        .fwd_pending (fwd_pending),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .data        (res_b),
        .pending     (pend_b)
    );

    // The oldest slot doubles as the writeback bypass, taken regardless of its valid bit
    assign wb_data = fwd_data[(NFWD-1)*XLEN +: XLEN];

    // Operand source muxes; the unused A encoding falls back to the resolved register
    always_comb begin
        next_a = res_a;
        next_b = res_b;
        case (opmux_a)
            OPMUX_A_RA: next_a = res_a;
            OPMUX_A_PC: next_a = id_pc;
            OPMUX_A_WB: next_a = wb_data;
            default:    next_a = res_a;
        endcase
        case (opmux_b)
            OPMUX_B_RB:  next_b = res_b;
            OPMUX_B_PC:  next_b = id_pc;
            OPMUX_B_IMM: next_b = imm;
            OPMUX_B_WB:  next_b = wb_data;
            default:     next_b = res_b;
        endcase
    end

    // Load-use stall: only operands actually read from a register can wait on a pending slot
    assign hazard = id_valid &&
                    (((opmux_a == OPMUX_A_RA) && (rega_addr != '0) && pend_a) ||
                     ((opmux_b == OPMUX_B_RB) && (regb_addr != '0) && pend_b));

    assign id_ready = rst && !flush && !hazard && (!ex_valid || ex_ready);
    assign accept   = id_valid && id_ready;

    // Pipeline register: reset, then flush, then accept, then consume, otherwise hold
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid  <= 1'b0;
            operand_a <= '0;
            operand_b <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid  <= 1'b1;
            operand_a <= next_a;
            operand_b <= next_b;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_core_operand_stage.sv
// Self-checking bench for core_operand_stage: a reference model predicts every accepted
// operand pair into a scoreboard queue and a monitor compares pairs as execute consumes them.
module tb_core_operand_stage;
    import i2d_core_defines::*;

    localparam int XLEN  = 32;
    localparam int NFWD  = 2;
    localparam int RADDR = 5;

    typedef struct {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } pair_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic                  id_valid;
    logic                  id_ready;
    opmux_a_t              opmux_a;
    opmux_b_t              opmux_b;
    logic [RADDR-1:0]      rega_addr;
    logic [RADDR-1:0]      regb_addr;
    logic [XLEN-1:0]       rega_data;
    logic [XLEN-1:0]       regb_data;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       id_pc;
    logic [NFWD-1:0]       slot_valid;
    logic [NFWD-1:0]       slot_pending;
    logic [RADDR-1:0]      slot_addr [NFWD];
    logic [XLEN-1:0]       slot_data [NFWD];
    logic [NFWD*RADDR-1:0] fwd_addr;
    logic [NFWD*XLEN-1:0]  fwd_data;
    logic                  ex_valid;
    logic                  ex_ready;
    logic [XLEN-1:0]       operand_a;
    logic [XLEN-1:0]       operand_b;
    logic                  hazard;

    int total = 0;
    int bad   = 0;

    // Reference model state: what execute should be seeing
    pair_t           sb_q[$];
    bit              m_valid = 1'b0;
    logic [XLEN-1:0] m_a = '0;
    logic [XLEN-1:0] m_b = '0;

    for (genvar g = 0; g < NFWD; g++) begin : g_pack
        assign fwd_addr[g*RADDR +: RADDR] = slot_addr[g];
        assign fwd_data[g*XLEN +: XLEN]   = slot_data[g];
    end

    core_operand_stage #(
        .XLEN  (XLEN),
        .NFWD  (NFWD),
        .RADDR (RADDR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .opmux_a     (opmux_a),
        .opmux_b     (opmux_b),
        .rega_addr   (rega_addr),
        .regb_addr   (regb_addr),
        .rega_data   (rega_data),
        .regb_data   (regb_data),
        .imm         (imm),
        .id_pc       (id_pc),
        .fwd_valid   (slot_valid),
        .fwd_pending (slot_pending),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .hazard      (hazard)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Register value as seen by the operand: first (youngest) matching slot, else the register file
    function automatic logic [XLEN-1:0] resolve(input logic [RADDR-1:0] a, input logic [XLEN-1:0] rf,
                                                output bit pend);
        pend = 1'b0;
        if (a == 0) return rf;
        for (int i = 0; i < NFWD; i++) begin
            if (slot_valid[i] && slot_addr[i] == a) begin
                pend = slot_pending[i];
                return slot_data[i];
            end
        end
        return rf;
    endfunction

    // Evaluate the model on the inputs already driven, check the handshake, then step one clock
    task automatic applyStimulus();
        logic [XLEN-1:0] ra, rb, ea, eb;
        bit pa, pb, exp_haz, exp_rdy;
        #1;
        ra = resolve(rega_addr, rega_data, pa);
        rb = resolve(regb_addr, regb_data, pb);
        exp_haz = id_valid && ((opmux_a == OPMUX_A_RA && rega_addr != 0 && pa) ||
                               (opmux_b == OPMUX_B_RB && regb_addr != 0 && pb));
        exp_rdy = rst && !flush && !exp_haz && (!m_valid || ex_ready);
        checkOutput("hazard", hazard, exp_haz);
        checkOutput("id_ready", id_ready, exp_rdy);
        case (opmux_a)
            OPMUX_A_PC: ea = id_pc;
            OPMUX_A_WB: ea = slot_data[NFWD-1];
            default:    ea = ra;
        endcase
        case (opmux_b)
            OPMUX_B_PC:  eb = id_pc;
            OPMUX_B_IMM: eb = imm;
            OPMUX_B_WB:  eb = slot_data[NFWD-1];
            default:     eb = rb;
        endcase
        if (!rst) begin
            m_valid = 1'b0; m_a = '0; m_b = '0;
            sb_q.delete();
        end else if (flush) begin
            m_valid = 1'b0;
            sb_q.delete();
        end else if (id_valid && exp_rdy) begin
            m_valid = 1'b1; m_a = ea; m_b = eb;
            sb_q.push_back('{a: ea, b: eb});
        end else if (ex_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        checkOutput("ex_valid", ex_valid, m_valid);
        checkOutput("operand_a_reg", operand_a, m_a);
        checkOutput("operand_b_reg", operand_b, m_b);
    endtask

    // Monitor: every pair execute takes must be the oldest predicted pair
    always @(negedge clk) begin
        if (rst && !flush && ex_valid && ex_ready) begin
            checkOutput("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                pair_t p;
                p = sb_q.pop_front();
                checkOutput("sb_operand_a", operand_a, p.a);
                checkOutput("sb_operand_b", operand_b, p.b);
            end
        end
    end

    task automatic clearInputs();
        rst = 1'b1; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b0;
        opmux_a = OPMUX_A_RA; opmux_b = OPMUX_B_RB;
        rega_addr = '0; regb_addr = '0; rega_data = '0; regb_data = '0;
        imm = '0; id_pc = '0; slot_valid = '0; slot_pending = '0;
        for (int i = 0; i < NFWD; i++) begin
            slot_addr[i] = '0;
            slot_data[i] = '0;
        end
    endtask

    task automatic randomizeInputs();
        rst      = ($urandom_range(0, 49) != 0);
        flush    = ($urandom_range(0, 11) == 0);
        id_valid = ($urandom_range(0, 9) < 7);
        ex_ready = ($urandom_range(0, 9) < 7);
        opmux_a  = opmux_a_t'($urandom_range(0, 2));
        opmux_b  = opmux_b_t'($urandom_range(0, 3));
        rega_addr = RADDR'($urandom_range(0, 3));
        regb_addr = RADDR'($urandom_range(0, 3));
        rega_data = $urandom; regb_data = $urandom;
        imm = $urandom; id_pc = $urandom;
        for (int i = 0; i < NFWD; i++) begin
            slot_valid[i]   = $urandom_range(0, 1) == 1;
            slot_pending[i] = $urandom_range(0, 3) == 0;
            slot_addr[i]    = RADDR'($urandom_range(0, 3));
            slot_data[i]    = $urandom;
        end
    endtask

    initial begin
        clearInputs();
        $display("[TB] start");

        // Reset with junk requests present
        rst = 1'b0; id_valid = 1'b1; ex_ready = 1'b1; rega_data = 32'hDEAD;
        applyStimulus();
        applyStimulus();
        checkOutput("reset_ex_valid", ex_valid, 0);
        checkOutput("reset_opa", operand_a, 0);
        checkOutput("reset_opb", operand_b, 0);

        // Youngest of several matching slots wins
        clearInputs();
        rega_addr = 5'd3; rega_data = 32'h1111;
        for (int i = 0; i < NFWD; i++) begin
            slot_valid[i] = 1'b1;
            slot_addr[i]  = 5'd3;
            slot_data[i]  = (i == 0) ? 32'hAAAA : 32'hBBBB;
        end
        id_valid = 1'b1; ex_ready = 1'b1;
        applyStimulus();
        checkOutput("youngest_slot_opa", operand_a, 64'hAAAA);

        // Register 0 never forwards
        clearInputs();
        regb_addr = '0; regb_data = 32'h5;
        slot_valid[0] = 1'b1; slot_addr[0] = '0; slot_data[0] = 32'h1234;
        id_valid = 1'b1; ex_ready = 1'b1;
        applyStimulus();
        checkOutput("reg0_opb", operand_b, 64'h5);

        // Load-use: fill the register, then hit a pending slot while execute drains
        clearInputs();
        rega_addr = 5'd7; rega_data = 32'h70; id_valid = 1'b1; ex_ready = 1'b1;
        applyStimulus();
        slot_valid[0] = 1'b1; slot_pending[0] = 1'b1; slot_addr[0] = 5'd7; slot_data[0] = 32'h77;
        #1;
        checkOutput("loaduse_hazard", hazard, 1);
        checkOutput("loaduse_id_ready", id_ready, 0);
        applyStimulus();
        checkOutput("loaduse_drained", ex_valid, 0);
        slot_pending[0] = 1'b0;
        applyStimulus();
        checkOutput("loaduse_accept", ex_valid, 1);
        checkOutput("loaduse_opa", operand_a, 64'h77);

        // Back-pressure for three cycles, then consume and accept together
        clearInputs();
        id_valid = 1'b1; opmux_b = OPMUX_B_IMM; imm = 32'h0C0FFEE0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("stall_id_ready", id_ready, 0);
        end
        ex_ready = 1'b1; imm = 32'h00BEEF00;
        applyStimulus();
        checkOutput("b2b_ex_valid", ex_valid, 1);
        checkOutput("b2b_opb", operand_b, 64'h00BEEF00);

        // Flush beats both the held pair and the incoming request
        imm = 32'h12345678; flush = 1'b1;
        applyStimulus();
        checkOutput("flush_ex_valid", ex_valid, 0);
        checkOutput("flush_no_load", operand_b, 64'h00BEEF00);

        // Reset in the middle of a transfer
        clearInputs();
        id_valid = 1'b1; ex_ready = 1'b1; rega_data = 32'h99;
        applyStimulus();
        rst = 1'b0; rega_data = 32'h98;
        applyStimulus();
        checkOutput("midreset_ex_valid", ex_valid, 0);
        checkOutput("midreset_opa", operand_a, 0);

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            randomizeInputs();
            applyStimulus();
        end

        // Drain whatever is still held
        clearInputs();
        ex_ready = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("sb_drained", 64'(sb_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
